// File: rtl/uart_crc_transmitter.sv
// UART frame transmitter: start bit, data byte LSB-first, CRC-16/XMODEM LSB-first, stop bit.
// The CRC is computed bit-serially over 8 clocks before the start bit is driven.
module uart_crc_transmitter #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [7:0]  data_in,
  output logic        tx_out,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [15:0] crc_out
);

  localparam int BAUD_COUNTER_MAX = CLK_FREQ / BAUD_RATE - 1;
  localparam int BAUD_W = (BAUD_COUNTER_MAX < 1) ? 1 : $clog2(BAUD_COUNTER_MAX + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_COUNTER_MAX);
  localparam logic [4:0] LAST_BIT = 5'd25;

  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

  state_t             state, state_n;
  logic [7:0]         data_reg, data_n;
  logic [15:0]        crc, crc_n, crc_step;
  logic [2:0]         bit_idx, bit_idx_n;
  logic [25:0]        shift_reg, shift_n;
  logic [BAUD_W-1:0]  baud_counter, baud_n;
  logic [4:0]         bit_counter, bit_counter_n;
  logic               busy_n, done_n, fb;
  logic [15:0]        crc_out_n;

  // The line is driven straight from the shift register LSB; it is refilled
  // with ones whenever no frame is in flight so the line idles high.
  assign tx_out = shift_reg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      data_reg     <= '0;
      crc          <= '0;
      bit_idx      <= '0;
      shift_reg    <= '1;
      baud_counter <= '0;
      bit_counter  <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      crc_out      <= '0;
    end else begin
      state        <= state_n;
      data_reg     <= data_n;
      crc          <= crc_n;
      bit_idx      <= bit_idx_n;
      shift_reg    <= shift_n;
      baud_counter <= baud_n;
      bit_counter  <= bit_counter_n;
      tx_busy      <= busy_n;
      tx_done      <= done_n;
      crc_out      <= crc_out_n;
    end
  end

  always_comb begin
    state_n       = state;
    data_n        = data_reg;
    crc_n         = crc;
    bit_idx_n     = bit_idx;
    shift_n       = shift_reg;
    baud_n        = baud_counter;
    bit_counter_n = bit_counter;
    busy_n        = tx_busy;
    done_n        = 1'b0;
    crc_out_n     = crc_out;

    fb       = crc[15] ^ data_reg[3'd7 - bit_idx];
    crc_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);

    case (state)
      IDLE: begin
        if (tx_start) begin
          data_n    = data_in;
          crc_n     = '0;
          bit_idx_n = '0;
          busy_n    = 1'b1;
          state_n   = CALC;
        end
      end
      CALC: begin
        crc_n     = crc_step;
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
          shift_n       = {1'b1, crc_step, data_reg, 1'b0};
          crc_out_n     = crc_step;
          baud_n        = '0;
          bit_counter_n = '0;
          state_n       = SEND;
        end
      end
      SEND: begin
        if (baud_counter == BAUD_LAST) begin
          baud_n = '0;
          if (bit_counter == LAST_BIT) begin
            bit_counter_n = '0;
            shift_n       = '1;
            busy_n        = 1'b0;
            done_n        = 1'b1;
            state_n       = IDLE;
          end else begin
            bit_counter_n = bit_counter + 5'd1;
            shift_n       = {1'b1, shift_reg[25:1]};
          end
        end else begin
          baud_n = baud_counter + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
